// File: rtl/imem_fetch_arbiter_pkg.sv
// imem_pkg: shared constants and state type for the instruction-memory fetch arbiter
package imem_pkg;
    localparam int IMEM_ADDR_W = 14;
    localparam int IMEM_BYTES = 16384;
    localparam logic [31:0] IMEM_NOP = 32'h0;
    typedef enum logic [1:0] {IDLE, RD, DRAIN, WR} imem_state_t;
endpackage

// File: rtl/imem_fetch_arbiter_rr_arb2.sv
// imem_rr_arb2: two-requester round-robin arbiter, pointer moves on every grant
module imem_rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_f,
    input  logic req_l,
    output logic gnt_f,
    output logic gnt_l
);
    logic last_ld;
    // a tie goes to whichever requester was not served last
    always_comb begin
        gnt_f = en && req_f && (!req_l || last_ld);
        gnt_l = en && req_l && (!req_f || !last_ld);
    end
    // remember who was served; reset leaves fetch with priority
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) last_ld <= 1'b1;
        else if (gnt_f || gnt_l) last_ld <= gnt_l;
endmodule

// File: rtl/imem_fetch_arbiter.sv
// imem_fetch_arbiter: sequences 32-bit fetches as four byte reads and interleaves loader writes
module imem_fetch_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    input  logic              fetch_flush,
    output logic              fetch_gnt,
    output logic              fetch_valid,
    output logic [31:0]       fetch_instr,
    output logic              fetch_err,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              ld_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);
    imem_state_t state, state_d;
    logic [1:0]  cnt;
    logic [23:0] bytes_q;
    logic        gnt_l, addr_err, fetch_ok;

    assign addr_err = (fetch_addr[1:0] != 2'b0) || ((fetch_addr >> ADDR_W) != 32'd0);
    assign fetch_ok = fetch_gnt && !addr_err;

    imem_rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == IDLE),
        .req_f (fetch_req),
        .req_l (ld_req),
        .gnt_f (fetch_gnt),
        .gnt_l (gnt_l)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_d;

    // next state and state-decoded memory strobes; a flush kills the read in its own cycle
    always_comb begin
        state_d = state == IDLE  ? (gnt_l ? WR : fetch_ok ? RD : IDLE)
                : state == RD    ? (fetch_flush ? IDLE : cnt == 2'd3 ? DRAIN : RD)
                : IDLE;
        mem_en  = (state == RD && !fetch_flush) || state == WR;
        mem_we  = state == WR;
        ld_ack  = state == WR;
        busy    = state != IDLE;
    end

    // address/data registers and big-endian byte assembly (first byte read ends up as MSB)
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt         <= 2'd0;
            bytes_q     <= 24'd0;
            mem_addr    <= '0;
            mem_wdata   <= 8'd0;
            fetch_instr <= IMEM_NOP;
            fetch_valid <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            fetch_valid <= 1'b0;
            fetch_err   <= 1'b0;
            if (fetch_gnt && addr_err) begin
                fetch_valid <= 1'b1;
                fetch_err   <= 1'b1;
                fetch_instr <= IMEM_NOP;
            end
            if (fetch_ok) begin
                mem_addr <= fetch_addr[ADDR_W-1:0];
                cnt      <= 2'd0;
            end
            if (gnt_l) begin
                mem_addr  <= ld_addr;
                mem_wdata <= ld_data;
            end
            if (state == RD && !fetch_flush) begin
                cnt <= cnt + 2'd1;
                if (cnt != 2'd3) mem_addr <= mem_addr + ADDR_W'(1);
                if (cnt != 2'd0) bytes_q <= {bytes_q[15:0], mem_rdata};
            end
            if (state == DRAIN && !fetch_flush) begin
                fetch_valid <= 1'b1;
                fetch_instr <= {bytes_q, mem_rdata};
            end
        end
endmodule
